sram_arb_2x1: RTL

SRAM_ARB_2X1 -- requirements
Module: sram_arb_2x1

---
 rtl/sram_arb_pkg.sv | 13 +
 rtl/sram_arb_pick.sv | 31 +++
 rtl/sram_arb_2x1.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the 2-to-1 SRAM-like arbiter: FSM states and master IDs.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic MST_I = 1'b0;
    localparam logic MST_D = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Two-input grant picker. Fixed D-over-I priority, or round-robin against the
// last-granted master when SRAM_ARB_RR_EN is defined.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_gnt,
    output logic gnt
);

`ifdef SRAM_ARB_RR_EN
    always_comb begin
        gnt = MST_I;
        if (req_i && req_d) begin
            gnt = ~last_gnt;
        end else if (req_d) begin
            gnt = MST_D;
        end
    end
`else
    logic unused_pick;
    assign unused_pick = req_i ^ last_gnt;

    // Only meaningful when some master is requesting; caller qualifies.
    always_comb begin
        gnt = req_d ? MST_D : MST_I;
    end
`endif

endmodule

// File: rtl/sram_arb_2x1.sv
// Arbitrates instruction and data SRAM-like masters onto one slave, one
// transaction outstanding. Define SRAM_ARB_RR_EN for round-robin contention.
module sram_arb_2x1
    import sram_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [DATA_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [DATA_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,

    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [DATA_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       owner_q, owner_d;
    logic       rr_q, rr_d;
    logic       pick_gnt;

    logic              g_req;
    logic              g_wr;
    logic [1:0]        g_size;
    logic [DATA_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    sram_arb_pick u_pick (
        .req_i    (inst_req),
        .req_d    (data_req),
        .last_gnt (rr_q),
        .gnt      (pick_gnt)
    );

    always_comb begin
        if (grant_q == MST_D) begin
            g_req   = data_req;
            g_wr    = data_wr;
            g_size  = data_size;
            g_addr  = data_addr;
            g_wdata = data_wdata;
        end else begin
            g_req   = inst_req;
            g_wr    = inst_wr;
            g_size  = inst_size;
            g_addr  = inst_addr;
            g_wdata = inst_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (inst_req || data_req) begin
                    grant_d = pick_gnt;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (s_addr_ok) begin
                    owner_d = grant_q;
                    rr_d    = grant_q;
                    state_d = ST_DATA;
                end else if (!g_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (s_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= MST_D;
            owner_q <= MST_D;
            rr_q    <= MST_I;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    // Handshakes are gated by state, so a slave ack outside its phase never leaks.
    assign s_req   = (state_q == ST_REQ) && g_req;
    assign s_wr    = g_wr;
    assign s_size  = g_size;
    assign s_addr  = g_addr;
    assign s_wdata = g_wdata;

    assign inst_addr_ok = (state_q == ST_REQ)  && (grant_q == MST_I) && s_addr_ok;
    assign data_addr_ok = (state_q == ST_REQ)  && (grant_q == MST_D) && s_addr_ok;
    assign inst_data_ok = (state_q == ST_DATA) && (owner_q == MST_I) && s_data_ok;
    assign data_data_ok = (state_q == ST_DATA) && (owner_q == MST_D) && s_data_ok;

    assign inst_rdata = s_rdata;
    assign data_rdata = s_rdata;

endmodule
